// File: rtl/uart_io_bridge_pkg.sv
// Shared word width, FIFO depth defaults and TX sequencer state codes for the UART bridge.
package uart_io_bridge_pkg;

    localparam int WORD              = 32;
    localparam int UART_RX_DEPTH_LOG = 4;
    localparam int UART_TX_DEPTH_LOG = 4;
    localparam int TX_TIMEOUT_LOG    = 4;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_LAUNCH  = 2'd1,
        TX_WAIT_HI = 2'd2,
        TX_WAIT_LO = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_io_bridge_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry an extra wrap bit for full/empty.
module sync_fifo_fwft
    import uart_io_bridge_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = UART_RX_DEPTH_LOG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [DEPTH_LOG:0] r_wr_ptr;
    logic [DEPTH_LOG:0] r_rd_ptr;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[DEPTH_LOG-1:0] == r_rd_ptr[DEPTH_LOG-1:0]) &&
                   (r_wr_ptr[DEPTH_LOG] != r_rd_ptr[DEPTH_LOG]);

    // A pop frees the slot first, so a push into a full FIFO is accepted when paired with a pop.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rd_ptr[DEPTH_LOG-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[DEPTH_LOG-1:0]] <= din;
    end

endmodule

// File: rtl/uart_io_bridge.sv
// Buffered byte bridge between the core's UART handshake and the raw serial RX/TX cores.
//   state      | meaning
//   TX_IDLE    | waiting for a queued byte and an idle transmitter
//   TX_LAUNCH  | tx_start pulse, byte already latched in tx_data
//   TX_WAIT_HI | waiting for transmitter to raise busy (timeout guarded)
//   TX_WAIT_LO | frame in flight, waiting for busy to drop
module uart_io_bridge
    import uart_io_bridge_pkg::*;
#(
    parameter int RX_DEPTH_LOG = UART_RX_DEPTH_LOG,
    parameter int TX_DEPTH_LOG = UART_TX_DEPTH_LOG
) (
    input  logic            clk,
    input  logic            rst,
    output logic            cpu_ready,
    output logic [WORD-1:0] cpu_r_data,
    input  logic            cpu_clear,
    output logic            cpu_busy,
    input  logic            cpu_start,
    input  logic [WORD-1:0] cpu_t_data,
    input  logic            rx_data_ready,
    input  logic [7:0]      rx_data,
    output logic            rx_clear,
    input  logic            tx_busy,
    output logic            tx_start,
    output logic [7:0]      tx_data,
    output logic            rx_overrun
);

    logic [7:0]                w_rx_head;
    logic                      w_rx_full;
    logic                      w_rx_empty;
    logic                      w_rx_capture;
    logic [7:0]                w_tx_head;
    logic                      w_tx_full;
    logic                      w_tx_empty;
    logic                      w_tx_pop;
    logic                      w_tx_load;
    logic                      w_unused_t_hi;
    tx_state_t                 r_state;
    tx_state_t                 w_state_next;
    logic [TX_TIMEOUT_LOG-1:0] r_timer;
    logic [TX_TIMEOUT_LOG-1:0] w_timer_next;
    logic                      r_rx_clear;
    logic                      r_rx_overrun;
    logic [7:0]                r_tx_data;

    assign w_unused_t_hi = ^cpu_t_data[WORD-1:8];

    // The receiver keeps ready high until it sees our ack, so skip the cycle right after an ack.
    assign w_rx_capture = rx_data_ready & ~r_rx_clear;

    sync_fifo_fwft #(.WIDTH(8), .DEPTH_LOG(RX_DEPTH_LOG)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_capture),
        .pop   (cpu_clear),
        .din   (rx_data),
        .dout  (w_rx_head),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    sync_fifo_fwft #(.WIDTH(8), .DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cpu_start),
        .pop   (w_tx_pop),
        .din   (cpu_t_data[7:0]),
        .dout  (w_tx_head),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    assign cpu_ready  = ~w_rx_empty;
    assign cpu_r_data = w_rx_empty ? '0 : {{(WORD-8){1'b0}}, w_rx_head};
    assign cpu_busy   = w_tx_full;
    assign rx_clear   = r_rx_clear;
    assign rx_overrun = r_rx_overrun;
    assign tx_data    = r_tx_data;
    assign tx_start   = (r_state == TX_LAUNCH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_clear   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_clear <= w_rx_capture;
            if (w_rx_capture && w_rx_full && !cpu_clear) r_rx_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= TX_IDLE;
            r_timer   <= '0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            if (w_tx_load) r_tx_data <= w_tx_head;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_tx_pop     = 1'b0;
        w_tx_load    = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (!w_tx_empty && !tx_busy) begin
                    w_tx_pop     = 1'b1;
                    w_tx_load    = 1'b1;
                    w_state_next = TX_LAUNCH;
                end
            end
            TX_LAUNCH: begin
                w_state_next = TX_WAIT_HI;
                w_timer_next = '1;
            end
            TX_WAIT_HI: begin
                if (tx_busy)            w_state_next = TX_WAIT_LO;
                else if (r_timer == '0) w_state_next = TX_IDLE;
                else                    w_timer_next = r_timer - 1'b1;
            end
            TX_WAIT_LO: begin
                if (!tx_busy) w_state_next = TX_IDLE;
            end
            default: w_state_next = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_io_bridge.sv
// Directed self-checking bench for uart_io_bridge with a simple transmitter busy model.
module tb_uart_io_bridge;

    logic        clk;
    logic        rst;
    logic        cpu_ready;
    logic [31:0] cpu_r_data;
    logic        cpu_clear;
    logic        cpu_busy;
    logic        cpu_start;
    logic [31:0] cpu_t_data;
    logic        rx_data_ready;
    logic [7:0]  rx_data;
    logic        rx_clear;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        rx_overrun;

    int          n_checks;
    int          n_fail;
    int          busy_cnt;
    logic        busy_hold;
    logic        no_resp;
    int          frames;
    int          overlap;
    logic [7:0]  tx_log [$];

    uart_io_bridge dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_ready     (cpu_ready),
        .cpu_r_data    (cpu_r_data),
        .cpu_clear     (cpu_clear),
        .cpu_busy      (cpu_busy),
        .cpu_start     (cpu_start),
        .cpu_t_data    (cpu_t_data),
        .rx_data_ready (rx_data_ready),
        .rx_data       (rx_data),
        .rx_clear      (rx_clear),
        .tx_busy       (tx_busy),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .rx_overrun    (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_busy = busy_hold | (busy_cnt != 0);

    // Transmitter model: busy for 10 cycles after each launch; logs every launched byte.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt <= 0;
        end else begin
            if (tx_start) begin
                frames = frames + 1;
                tx_log.push_back(tx_data);
                if (tx_busy) overlap = overlap + 1;
                if (!no_resp) busy_cnt <= 10;
            end else if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    typedef struct {
        logic        rdr;
        logic [7:0]  rdata;
        logic        clr;
        logic        exp_clear;
        logic        exp_ready;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        cpu_clear     = 1'b0;
        cpu_start     = 1'b0;
        cpu_t_data    = '0;
        rx_data_ready = 1'b0;
        rx_data       = '0;
        busy_hold     = 1'b0;
        no_resp       = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic feed_rx(input logic [7:0] b);
        rx_data_ready = 1'b1;
        rx_data       = b;
        tick();
        rx_data_ready = 1'b0;
        tick();
    endtask

    task automatic push_tx(input logic [31:0] d);
        cpu_start  = 1'b1;
        cpu_t_data = d;
        tick();
        cpu_start  = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (frames < target && k < budget) begin
            tick();
            k++;
        end
        check(name, (frames >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int base;
        int gap;
        int k;
        n_checks = 0;
        n_fail   = 0;
        frames   = 0;
        overlap  = 0;
        rst      = 1'b0;
        busy_hold = 1'b0;
        no_resp   = 1'b0;
        cpu_clear = 1'b0; cpu_start = 1'b0; cpu_t_data = '0;
        rx_data_ready = 1'b0; rx_data = '0;
        #2;
        check("rst_ready",   {31'b0, cpu_ready},  32'd0);
        check("rst_busy",    {31'b0, cpu_busy},   32'd0);
        check("rst_rdata",   cpu_r_data,          32'd0);
        check("rst_rxclear", {31'b0, rx_clear},   32'd0);
        check("rst_txstart", {31'b0, tx_start},   32'd0);
        check("rst_txdata",  {24'b0, tx_data},    32'd0);
        check("rst_overrun", {31'b0, rx_overrun}, 32'd0);
        do_reset();

        // RX handshake / FWFT table
        vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 32'h41};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h41};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h00};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h00};
        vecs[4]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 32'h5A};
        vecs[5]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 32'h5A};
        vecs[6]  = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 32'h5A};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'hC3};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h00};
        vecs[9]  = '{1'b1, 8'h99, 1'b1, 1'b1, 1'b1, 32'h99};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h00};
        for (int i = 0; i < 11; i++) begin
            rx_data_ready = vecs[i].rdr;
            rx_data       = vecs[i].rdata;
            cpu_clear     = vecs[i].clr;
            tick();
            check($sformatf("vec%0d_rxclear", i), {31'b0, rx_clear},  {31'b0, vecs[i].exp_clear});
            check($sformatf("vec%0d_ready", i),   {31'b0, cpu_ready}, {31'b0, vecs[i].exp_ready});
            check($sformatf("vec%0d_rdata", i),   cpu_r_data,         vecs[i].exp_rdata);
        end
        rx_data_ready = 1'b0;
        cpu_clear     = 1'b0;
        check("tbl_overrun", {31'b0, rx_overrun}, 32'd0);

        // RX overrun: 17 bytes into a 16-entry FIFO
        do_reset();
        for (int i = 0; i < 16; i++) feed_rx(8'(i));
        check("ovr_before", {31'b0, rx_overrun}, 32'd0);
        rx_data_ready = 1'b1;
        rx_data       = 8'h10;
        tick();
        check("ovr_ack", {31'b0, rx_clear}, 32'd1);
        rx_data_ready = 1'b0;
        tick();
        check("ovr_set", {31'b0, rx_overrun}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovr_pop%0d", i), cpu_r_data, 32'(i));
            cpu_clear = 1'b1;
            tick();
            cpu_clear = 1'b0;
        end
        check("ovr_empty", {31'b0, cpu_ready}, 32'd0);
        check("ovr_sticky", {31'b0, rx_overrun}, 32'd1);

        // Simultaneous pop and capture while full
        do_reset();
        for (int i = 0; i < 16; i++) feed_rx(8'(i));
        rx_data_ready = 1'b1;
        rx_data       = 8'h7E;
        cpu_clear     = 1'b1;
        tick();
        rx_data_ready = 1'b0;
        cpu_clear     = 1'b0;
        check("sim_ack", {31'b0, rx_clear}, 32'd1);
        check("sim_head", cpu_r_data, 32'h01);
        tick();
        check("sim_no_ovr", {31'b0, rx_overrun}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("sim_pop%0d", i), cpu_r_data, 32'(i + 1));
            cpu_clear = 1'b1;
            tick();
            cpu_clear = 1'b0;
        end
        check("sim_last", cpu_r_data, 32'h7E);
        cpu_clear = 1'b1;
        tick();
        cpu_clear = 1'b0;
        check("sim_empty", {31'b0, cpu_ready}, 32'd0);

        // TX ordering
        do_reset();
        base    = frames;
        overlap = 0;
        push_tx(32'hFFFF_FF55);
        push_tx(32'h0000_00AA);
        wait_frames(base + 2, 200, "tx2_done");
        repeat (20) tick();
        check("tx2_count", 32'(frames - base), 32'd2);
        check("tx2_b0", {24'b0, tx_log[base]},     32'h55);
        check("tx2_b1", {24'b0, tx_log[base + 1]}, 32'hAA);
        check("tx2_overlap", 32'(overlap), 32'd0);
        check("tx2_hold", {24'b0, tx_data}, 32'hAA);

        // TX full and dropped 17th byte
        do_reset();
        base      = frames;
        busy_hold = 1'b1;
        for (int i = 0; i < 15; i++) push_tx(32'hABCD_0010 + 32'(i));
        check("txf_not_full", {31'b0, cpu_busy}, 32'd0);
        push_tx(32'hABCD_001F);
        check("txf_full", {31'b0, cpu_busy}, 32'd1);
        push_tx(32'h0000_00EE);
        check("txf_still_full", {31'b0, cpu_busy}, 32'd1);
        busy_hold = 1'b0;
        wait_frames(base + 16, 1000, "txf_done");
        repeat (50) tick();
        check("txf_count", 32'(frames - base), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("txf_b%0d", i), {24'b0, tx_log[base + i]}, 32'h10 + 32'(i));
        check("txf_overlap", 32'(overlap), 32'd0);

        // Busy-never-rises timeout: launches spaced by 1 + 1 + 16 cycles
        do_reset();
        no_resp = 1'b1;
        push_tx(32'h11);
        push_tx(32'h22);
        k = 0;
        while (!tx_start && k < 20) begin tick(); k++; end
        check("to_first", {31'b0, tx_start}, 32'd1);
        gap = 0;
        tick();
        gap = 1;
        while (!tx_start && gap < 40) begin tick(); gap++; end
        check("to_gap", 32'(gap), 32'd18);
        check("to_data", {24'b0, tx_data}, 32'h22);
        no_resp = 1'b0;

        // Reset during WAIT_LO with TX and RX bytes queued
        do_reset();
        for (int i = 0; i < 4; i++) push_tx(32'hA1 + 32'(i));
        feed_rx(8'h31);
        feed_rx(8'h32);
        k = 0;
        while (!tx_busy && k < 40) begin tick(); k++; end
        check("rst6_busy_seen", {31'b0, tx_busy}, 32'd1);
        tick();
        check("rst6_pre_ready", {31'b0, cpu_ready}, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("rst6_ready",   {31'b0, cpu_ready},  32'd0);
        check("rst6_busy",    {31'b0, cpu_busy},   32'd0);
        check("rst6_rdata",   cpu_r_data,          32'd0);
        check("rst6_rxclear", {31'b0, rx_clear},   32'd0);
        check("rst6_txstart", {31'b0, tx_start},   32'd0);
        check("rst6_txdata",  {24'b0, tx_data},    32'd0);
        check("rst6_overrun", {31'b0, rx_overrun}, 32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        base = frames;
        repeat (40) tick();
        check("rst6_quiet", 32'(frames - base), 32'd0);
        check("rst6_rx_empty", {31'b0, cpu_ready}, 32'd0);
        push_tx(32'h3C);
        wait_frames(base + 1, 40, "rst6_new");
        check("rst6_new_data", {24'b0, tx_log[frames - 1]}, 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
